// File: rtl/gpio_input_capture_if.sv
// Peripheral-bus bundle for the GPIO input block: byte address, write strobe and data,
// plus the combinational read-data return path.
interface gpio_input_capture_if;
    logic [31:0] Adr_in;
    logic        WE;
    logic [31:0] Data_in;
    logic [31:0] Data_out;

    modport master (
        output Adr_in,
        output WE,
        output Data_in,
        input  Data_out
    );

    modport slave (
        input  Adr_in,
        input  WE,
        input  Data_in,
        output Data_out
    );
endinterface

// File: rtl/gpio_input_capture.sv
// GPIO input peripheral: synchronise/debounce pins, sticky W1C edge events, maskable level irq.
// Define GPIO_IN_DEBOUNCE_EN to build the per-pin debounce counters; otherwise pins pass straight through.
module gpio_input_capture #(
    parameter int          WIDTH           = 8,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0040,
    parameter int          DEBOUNCE_COUNTS = 50_000
) (
    input  logic                clk,
    input  logic                rst,
    gpio_input_capture_if.slave bus,
    input  logic [WIDTH-1:0]    switches,
    output logic                irq
);

    localparam logic [1:0] OFF_DATA = 2'd0;
    localparam logic [1:0] OFF_RISE = 2'd1;
    localparam logic [1:0] OFF_FALL = 2'd2;
    localparam logic [1:0] OFF_MASK = 2'd3;

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic             irq_q;
    logic             irq_d;

    logic             hit;
    logic [1:0]       offset;
    logic             wr_rise;
    logic             wr_fall;
    logic             wr_mask;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rise_set;
    logic [WIDTH-1:0] fall_set;
    logic [WIDTH-1:0] rd_field;

    // Address decode; the two byte-lane bits are don't-care.
    assign hit     = (bus.Adr_in[31:4] == BASE_ADDR[31:4]);
    assign offset  = bus.Adr_in[3:2];
    assign wdata   = bus.Data_in[WIDTH-1:0];
    assign wr_rise = bus.WE && hit && (offset == OFF_RISE);
    assign wr_fall = bus.WE && hit && (offset == OFF_FALL);
    assign wr_mask = bus.WE && hit && (offset == OFF_MASK);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync_q  <= '0;
        end else begin
            sync1_q <= switches;
            sync_q  <= sync1_q;
        end
    end

`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int               CNT_W   = $clog2(DEBOUNCE_COUNTS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_COUNTS - 1);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             stable_bit_d;

            // A return to the accepted level before terminal count restarts the count.
            always_comb begin
                cnt_d        = cnt_q;
                stable_bit_d = stable_q[gi];
                if (sync_q[gi] == stable_q[gi]) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    stable_bit_d = sync_q[gi];
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign stable_d[gi] = stable_bit_d;
        end
    endgenerate
`else
    assign stable_d = sync_q;
`endif

    // Edges are flagged on the same clock that the accepted level changes.
    assign rise_set = stable_d & ~stable_q;
    assign fall_set = ~stable_d & stable_q;

    always_comb begin
        rise_d = rise_q;
        fall_d = fall_q;
        mask_d = mask_q;
        if (wr_rise) begin
            rise_d = rise_q & ~wdata;
        end
        if (wr_fall) begin
            fall_d = fall_q & ~wdata;
        end
        if (wr_mask) begin
            mask_d = wdata;
        end
        rise_d = rise_d | rise_set;
        fall_d = fall_d | fall_set;
    end

    assign irq_d = |((rise_q | fall_q) & mask_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            mask_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            mask_q   <= mask_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        rd_field = '0;
        case (offset)
            OFF_DATA: rd_field = stable_q;
            OFF_RISE: rd_field = rise_q;
            OFF_FALL: rd_field = fall_q;
            OFF_MASK: rd_field = mask_q;
            default:  rd_field = '0;
        endcase
    end

    assign bus.Data_out = hit ? 32'(rd_field) : 32'h0;
    assign irq          = irq_q;

endmodule

// File: tb/tb_gpio_input_capture.sv
// Scoreboard bench for gpio_input_capture: expectations queued with each stimulus step, drained by bus reads.
module tb_gpio_input_capture;

    localparam int WIDTH = 8;
    localparam int DEB   = 4;
`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int          LAT         = 2 + DEB;
    localparam logic [31:0] BOUNCE_FALL = 32'h00;
`else
    localparam int          LAT         = 3;
    localparam logic [31:0] BOUNCE_FALL = 32'h01;
`endif
    localparam logic [31:0] IRQ_SEL = 32'hFFFF_FFFF;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] switches = '0;
    logic             irq;

    gpio_input_capture_if bus_if ();

    gpio_input_capture #(
        .WIDTH          (WIDTH),
        .BASE_ADDR      (32'h0000_0040),
        .DEBOUNCE_COUNTS(DEB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_if),
        .switches(switches),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] addr;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        bus_if.Adr_in = addr;
        bus_if.WE     = 1'b0;
        #1;
        data = bus_if.Data_out;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bus_if.Adr_in  = addr;
        bus_if.Data_in = data;
        bus_if.WE      = 1'b1;
        tick(1);
        bus_if.WE      = 1'b0;
        bus_if.Data_in = 32'h0;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        exp_t e;
        e.tag  = tag;
        e.addr = addr;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.addr == IRQ_SEL) begin
                obs = {31'b0, irq};
            end else begin
                bus_read(e.addr, obs);
            end
            check_val(e.tag, obs, e.exp);
        end
    endtask

    task automatic clear_events();
        bus_write(32'h44, 32'hFF);
        bus_write(32'h48, 32'hFF);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.Adr_in  = 32'h40;
        bus_if.WE      = 1'b0;
        bus_if.Data_in = 32'h0;

        // Reset with all pins high, then release.
        rst      = 1'b0;
        switches = 8'hFF;
        tick(2);
        expect_val("rst_data", 32'h40, 32'h00);
        expect_val("rst_irq",  IRQ_SEL, 32'h0);
        expect_val("rst_rise", 32'h44, 32'h00);
        drain();
        rst = 1'b1;
        tick(LAT - 1);
        expect_val("rel_data_early", 32'h40, 32'h00);
        drain();
        tick(1);
        expect_val("rel_data", 32'h40, 32'hFF);
        expect_val("rel_rise", 32'h44, 32'hFF);
        expect_val("rel_fall", 32'h48, 32'h00);
        expect_val("rel_irq",  IRQ_SEL, 32'h0);
        drain();

        switches = 8'h00;
        tick(LAT + 1);
        clear_events();
        expect_val("idle_rise", 32'h44, 32'h00);
        expect_val("idle_fall", 32'h48, 32'h00);
        drain();

        // Bounce on pin 0: short pulses, then hold high.
        for (int i = 0; i < 6; i++) begin
            switches[0] = ~switches[0];
            tick(2);
        end
`ifdef GPIO_IN_DEBOUNCE_EN
        expect_val("bounce_mid_data", 32'h40, 32'h00);
        expect_val("bounce_mid_rise", 32'h44, 32'h00);
        drain();
`endif
        switches[0] = 1'b1;
        tick(LAT - 1);
        expect_val("bounce_data_early", 32'h40, 32'h00);
        drain();
        tick(1);
        expect_val("bounce_data", 32'h40, 32'h01);
        expect_val("bounce_rise", 32'h44, 32'h01);
        expect_val("bounce_fall", 32'h48, BOUNCE_FALL);
        drain();

        // W1C behaviour.
        switches = 8'h00;
        tick(LAT + 1);
        clear_events();
        switches = 8'h05;
        tick(LAT + 1);
        expect_val("w1c_pre", 32'h44, 32'h05);
        drain();
        bus_write(32'h44, 32'h01);
        expect_val("w1c_clr1", 32'h44, 32'h04);
        drain();
        bus_write(32'h44, 32'h00);
        expect_val("w1c_clr0", 32'h44, 32'h04);
        drain();

        // Clear of bit 1 lands on the same edge as its rise event.
        switches = 8'h07;
        tick(LAT - 1);
        expect_val("setclr_pre", 32'h44, 32'h04);
        drain();
        bus_write(32'h44, 32'h02);
        expect_val("setclr_rise", 32'h44, 32'h06);
        expect_val("setclr_data", 32'h40, 32'h07);
        drain();

        // Interrupt via masked fall on pin 7.
        clear_events();
        switches = 8'h87;
        tick(LAT + 1);
        clear_events();
        bus_write(32'h4C, 32'h80);
        tick(1);
        expect_val("irq_masked_idle", IRQ_SEL, 32'h0);
        expect_val("irq_mask_rd",     32'h4C, 32'h80);
        drain();
        switches = 8'h07;
        tick(LAT);
        expect_val("irq_fall",      32'h48, 32'h80);
        expect_val("irq_not_yet",   IRQ_SEL, 32'h0);
        drain();
        tick(1);
        expect_val("irq_set", IRQ_SEL, 32'h1);
        drain();
        bus_write(32'h48, 32'h80);
        expect_val("irq_fall_clr", 32'h48, 32'h00);
        expect_val("irq_hold",     IRQ_SEL, 32'h1);
        drain();
        tick(1);
        expect_val("irq_drop", IRQ_SEL, 32'h0);
        drain();
        switches = 8'h06;
        tick(LAT + 2);
        expect_val("irq_unmasked_fall", 32'h48, 32'h01);
        expect_val("irq_unmasked",      IRQ_SEL, 32'h0);
        drain();

        // Multi-pin change, decode and write-ignore checks.
        switches = 8'h00;
        tick(LAT + 1);
        clear_events();
        switches = 8'h3C;
        tick(LAT - 1);
        expect_val("multi_data_early", 32'h40, 32'h00);
        drain();
        tick(1);
        expect_val("multi_data",  32'h40, 32'h3C);
        expect_val("multi_rise",  32'h44, 32'h3C);
        expect_val("miss_50",     32'h50, 32'h00);
        expect_val("byte_offset", 32'h41, 32'h3C);
        drain();
        bus_write(32'h40, 32'hFF);
        bus_write(32'h4C, 32'hFFFF_FF81);
        expect_val("data_ro",   32'h40, 32'h3C);
        expect_val("mask_wide", 32'h4C, 32'h81);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
